// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between the CPU PC and a byte-wide,
// variable-latency instruction memory. Four byte reads per word are
// assembled little-endian into a one-word line buffer; BUSYWAIT stalls
// the CPU while a fetch is outstanding.
// Optional feature macro: IFETCH_PREFETCH_EN (adds a next-line prefetch entry).
module instr_fetch_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       PC,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  output logic              FAULT,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_READ,
  input  logic [7:0]        MEM_RDATA,
  input  logic              MEM_VALID
);
  localparam int TW = ADDR_W - 2;

`ifdef IFETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, FETCH, FILL, PREFETCH} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;
`endif

  state_t          state, state_nxt;
  logic [31:0]     buf_data, asm_data;
  logic [TW-1:0]   buf_tag, fetch_tag, pc_tag;
  logic            buf_valid;
  logic [1:0]      k;
  logic            pc_fault, dhit, hit;

  assign pc_tag   = PC[ADDR_W-1:2];
  assign pc_fault = (PC[1:0] != 2'b00) || (PC[31:ADDR_W] != '0);
  assign dhit     = buf_valid && (buf_tag == pc_tag);

`ifdef IFETCH_PREFETCH_EN
  logic [31:0]     pf_data;
  logic [TW-1:0]   pf_tag;
  logic            pf_valid, phit;
  // Prefetch entry only counts when the demand entry misses, so a pf hit
  // always means "copy into the demand entry".
  assign phit = pf_valid && (pf_tag == pc_tag) && !dhit;
  assign hit  = dhit || phit;
`else
  assign hit  = dhit;
`endif

  // Next state and all combinational outputs
  always_comb begin
    state_nxt   = state;
    MEM_READ    = 1'b0;
    MEM_ADDR    = '0;
    INSTRUCTION = '0;
    BUSYWAIT    = 1'b1;
    FAULT       = pc_fault;
    unique case (state)
      IDLE: begin
        BUSYWAIT = !hit && !pc_fault;
        if (!pc_fault && dhit) INSTRUCTION = buf_data;
`ifdef IFETCH_PREFETCH_EN
        if (!pc_fault && phit) INSTRUCTION = pf_data;
`endif
        if (!pc_fault && !hit) state_nxt = FETCH;
      end
      FETCH: begin
        MEM_READ = 1'b1;
        MEM_ADDR = {fetch_tag, k};
        if (MEM_VALID && k == 2'd3) state_nxt = FILL;
      end
      FILL: begin
`ifdef IFETCH_PREFETCH_EN
        // fetch_tag == all-ones means the next line is out of range
        state_nxt = (fetch_tag != '1) ? PREFETCH : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
`ifdef IFETCH_PREFETCH_EN
      PREFETCH: begin
        MEM_READ = 1'b1;
        MEM_ADDR = {fetch_tag, k};
        BUSYWAIT = !dhit && !pc_fault;
        if (!pc_fault && dhit) INSTRUCTION = buf_data;
        // A demand miss waits for the byte in flight, then drops the prefetch
        if (MEM_VALID) begin
          if (!pc_fault && !dhit) state_nxt = FETCH;
          else if (k == 2'd3)     state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State, byte assembly and line buffer update
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      k         <= 2'd0;
      buf_valid <= 1'b0;
      buf_data  <= '0;
      buf_tag   <= '0;
      fetch_tag <= '0;
      asm_data  <= '0;
`ifdef IFETCH_PREFETCH_EN
      pf_valid  <= 1'b0;
      pf_data   <= '0;
      pf_tag    <= '0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (!pc_fault && !hit) begin
            fetch_tag <= pc_tag;
            k         <= 2'd0;
          end
`ifdef IFETCH_PREFETCH_EN
          else if (!pc_fault && phit) begin
            buf_data  <= pf_data;
            buf_tag   <= pf_tag;
            buf_valid <= 1'b1;
          end
`endif
        end
        FETCH: begin
          if (MEM_VALID) begin
            asm_data[{k, 3'b000} +: 8] <= MEM_RDATA;
            k <= k + 2'd1;
          end
        end
        FILL: begin
          buf_data  <= asm_data;
          buf_tag   <= fetch_tag;
          buf_valid <= 1'b1;
          k         <= 2'd0;
`ifdef IFETCH_PREFETCH_EN
          // prefetch target is the next line; old prefetch entry is stale
          fetch_tag <= fetch_tag + 1'b1;
          pf_valid  <= 1'b0;
`endif
        end
`ifdef IFETCH_PREFETCH_EN
        PREFETCH: begin
          if (MEM_VALID) begin
            if (state_nxt == FETCH) begin
              fetch_tag <= pc_tag;
              k         <= 2'd0;
              pf_valid  <= 1'b0;
            end else begin
              asm_data[{k, 3'b000} +: 8] <= MEM_RDATA;
              k <= k + 2'd1;
              if (k == 2'd3) begin
                pf_data  <= {MEM_RDATA, asm_data[23:0]};
                pf_tag   <= fetch_tag;
                pf_valid <= 1'b1;
              end
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit (default build): directed scenarios followed by
// randomized PC / MEM_VALID / RESET traffic, all checked every cycle against
// a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;
  localparam int AW = 10;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc;
  logic [31:0]   instruction;
  logic          busywait, fault, mem_read, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    mem [0:MEMSZ-1];

  int errors = 0;
  int checks = 0;

  // Model: one cached word, plus an outstanding-fetch descriptor
  bit            m_valid;
  logic [AW-3:0] m_tag;
  bit            pending;
  logic [AW-3:0] f_tag;
  int            bytes_left;

  // Values observed in the last cycle
  logic          obs_busy, obs_read, obs_fault;
  logic [31:0]   obs_instr;
  logic [AW-1:0] obs_addr;
  logic [AW-1:0] addr_log[$];

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : 8'hA5;

  instr_fetch_unit #(.ADDR_W(AW)) dut (
    .CLK(clk), .RESET(rst_n), .PC(pc), .INSTRUCTION(instruction),
    .BUSYWAIT(busywait), .FAULT(fault), .MEM_ADDR(mem_addr),
    .MEM_READ(mem_read), .MEM_RDATA(mem_rdata), .MEM_VALID(mem_valid)
  );

  function automatic bit is_fault(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p >= MEMSZ);
  endfunction

  function automatic logic [31:0] word_at(input logic [AW-3:0] t);
    int a;
    a = int'(t) * 4;
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model at negedge, step model at posedge
  task automatic cyc(input logic r, input logic [31:0] p, input logic v);
    bit            ef, eh, eb, er;
    logic [31:0]   ei;
    logic [AW-1:0] ea;
    rst_n = r; pc = p; mem_valid = v;
    @(negedge clk);
    ef = is_fault(p);
    eh = !ef && m_valid && (m_tag == p[AW-1:2]);
    eb = pending || (!eh && !ef);
    ei = (!pending && eh) ? word_at(m_tag) : 32'h0;
    er = pending && (bytes_left > 0);
    ea = er ? {f_tag, 2'(4 - bytes_left)} : '0;
    chk("fault", {31'h0, fault}, {31'h0, ef});
    chk("busywait", {31'h0, busywait}, {31'h0, eb});
    chk("instruction", instruction, ei);
    chk("mem_read", {31'h0, mem_read}, {31'h0, er});
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    obs_busy = busywait; obs_read = mem_read; obs_fault = fault;
    obs_instr = instruction; obs_addr = mem_addr;
    if (mem_read && v) addr_log.push_back(mem_addr);
    @(posedge clk);
    if (!r) begin
      m_valid = 0; m_tag = '0; pending = 0; bytes_left = 0;
    end else if (pending) begin
      if (bytes_left > 0) begin
        if (v) bytes_left--;
      end else begin
        m_valid = 1; m_tag = f_tag; pending = 0;
      end
    end else if (!ef && !eh) begin
      pending = 1; f_tag = p[AW-1:2]; bytes_left = 4;
    end
    #1;
  endtask

  // Hold PC with MEM_VALID high until BUSYWAIT drops; nb = busy cycles seen
  task automatic fetch_all(input logic [31:0] p, output int nb);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, p, 1'b1);
      if (!obs_busy) return;
      nb++;
    end
    checks++; errors++;
    $display("FAIL fetch_timeout: pc %h still busy after 30 cycles", p);
  endtask

  function automatic logic [31:0] pick_pc();
    int r;
    logic [31:0] t;
    r = $urandom_range(0, 19);
    t = 32'($urandom_range(0, 7)) * 4;
    if (r == 0)      return t + 32'($urandom_range(1, 3));
    else if (r == 1) return 32'h400 + t;
    else if (r == 2) return 32'h3FC;
    else             return t;
  endfunction

  initial begin
    int nb, nv, last_v, rel;
    logic [31:0] cur_pc;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h32; mem[2] = 8'h54; mem[3] = 8'h76;
    m_valid = 0; m_tag = '0; pending = 0; f_tag = '0; bytes_left = 0;

    // Unchecked first edge: state is unknown until reset is sampled
    rst_n = 1'b0; pc = 32'h0; mem_valid = 1'b0;
    @(posedge clk); #1;

    // Reset state
    cyc(1'b0, 32'h0, 1'b0);
    chk("rst_mem_read", {31'h0, obs_read}, 32'h0);
    chk("rst_mem_addr", 32'(obs_addr), 32'h0);
    chk("rst_instr", obs_instr, 32'h0);
    chk("rst_busy", {31'h0, obs_busy}, 32'h1);

    // Cold miss at PC=0 with zero wait states
    addr_log.delete();
    fetch_all(32'h0, nb);
    chk("miss_busy_cycles", 32'(nb), 32'd6);
    chk("miss_instr", obs_instr, 32'h76543210);
    chk("miss_nbytes", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("miss_addr_seq", 32'(addr_log[i]), 32'(i));

    // Re-present PC=0: immediate hit, no memory traffic
    cyc(1'b1, 32'h0, 1'b1);
    chk("hit_busy", {31'h0, obs_busy}, 32'h0);
    chk("hit_read", {31'h0, obs_read}, 32'h0);
    chk("hit_instr", obs_instr, 32'h76543210);

    // MEM_VALID every 3rd cycle at PC=8
    nv = 0; last_v = -1; rel = -1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 32'h8, (i % 3) == 2);
      if (obs_read && (i % 3) == 2) begin nv++; last_v = i; end
      if (!obs_busy) begin rel = i; break; end
    end
    chk("slow_transfers", 32'(nv), 32'd4);
    chk("slow_release_gap", 32'(rel - last_v), 32'd2);
    chk("slow_instr", obs_instr, {mem[11], mem[10], mem[9], mem[8]});

    // Faults: misaligned and out of range
    cyc(1'b1, 32'h2, 1'b1);
    chk("mis_fault", {31'h0, obs_fault}, 32'h1);
    chk("mis_busy", {31'h0, obs_busy}, 32'h0);
    chk("mis_instr", obs_instr, 32'h0);
    chk("mis_read", {31'h0, obs_read}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400, 1'b1);
    chk("oor_fault", {31'h0, obs_fault}, 32'h1);
    chk("oor_busy", {31'h0, obs_busy}, 32'h0);
    chk("oor_read", {31'h0, obs_read}, 32'h0);

    // Highest legal word
    fetch_all(32'h3FC, nb);
    chk("top_busy_cycles", 32'(nb), 32'd6);
    chk("top_fault", {31'h0, obs_fault}, 32'h0);

    // Reset during the byte-2 read of a fetch at PC=0x10
    cyc(1'b1, 32'h10, 1'b1);
    cyc(1'b1, 32'h10, 1'b1);
    cyc(1'b1, 32'h10, 1'b1);
    cyc(1'b0, 32'h10, 1'b1);
    chk("rf_byte2_addr", 32'(obs_addr), 32'h12);
    fetch_all(32'h0, nb);
    chk("rf_refetch_cycles", 32'(nb), 32'd6);
    chk("rf_instr", obs_instr, 32'h76543210);

    // Random traffic
    cur_pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) cur_pc = pick_pc();
      cyc($urandom_range(0, 99) != 0, cur_pc, $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Instruction fetch stage between the CPU program counter and a byte-wide, variable-latency instruction memory (1 KB by default).
- Takes the CPU's byte-address `PC`, reads four consecutive bytes and assembles them little-endian into a 32-bit `INSTRUCTION`.
- Holds the most recent word in a line buffer and stalls the CPU with `BUSYWAIT` while a fetch is outstanding.
- Replaces the ideal zero-wait fetch model in system simulation with realistic memory timing.

## Interface
- `ADDR_W`, default 10: byte-address width of instruction memory; capacity is 2^ADDR_W bytes.
- `CLK` in 1: system clock; all state updates on rising edge.
- `RESET` in 1: synchronous, active-low reset (sampled on `CLK` rising edge; 0 = reset).
- `PC` in 32: byte address of the requested instruction, driven by the CPU.
- `INSTRUCTION` out 32: assembled instruction word.
- `BUSYWAIT` out 1: CPU must hold `PC` and stall while high.
- `FAULT` out 1: `PC` misaligned or out of range.
- `MEM_ADDR` out ADDR_W: byte address to instruction memory.
- `MEM_READ` out 1: byte read request.
- `MEM_RDATA` in 8: read byte.
- `MEM_VALID` in 1: `MEM_RDATA` valid this cycle; completes the current byte read.

## Operation
- Line buffer fields:
  - `buf_data[31:0]`
  - `buf_tag[ADDR_W-3:0]`
  - `buf_valid`
- Hit: `buf_valid && buf_tag == PC[ADDR_W-1:2]`.
- Fault: `PC[1:0] != 0` or `PC[31:ADDR_W] != 0`. Fault overrides hit and miss:
  - `FAULT=1`, `BUSYWAIT=0`, `INSTRUCTION=32'h0`.
  - No fetch is started.
- Combinational outputs while in IDLE:
  - `INSTRUCTION = buf_data` on hit, else 0.
  - `BUSYWAIT = !hit && !fault`.
  - In any non-IDLE state, `BUSYWAIT=1`.
- FSM states:
  - **IDLE**: on miss without fault, latch `fetch_tag = PC[ADDR_W-1:2]`, set `k=0`, go to FETCH.
  - **FETCH**: `MEM_READ=1`, `MEM_ADDR={fetch_tag, k[1:0]}`. On `MEM_VALID`, write `MEM_RDATA` into byte lane k (lane 0 = bits 7:0) and increment k. When `MEM_VALID` arrives with k=3, go to FILL.
  - **FILL**: write `buf_data`, `buf_tag=fetch_tag`, `buf_valid=1`; return to IDLE. `MEM_READ=0`.
- Handshake:
  - `MEM_ADDR` is stable while `MEM_READ` is high until `MEM_VALID`.
  - Exactly one byte transfers per `MEM_VALID` cycle.
  - `MEM_VALID` while `MEM_READ=0` is ignored.
- A `PC` change during FETCH does not abort the fetch. The fill completes for `fetch_tag`, then IDLE re-evaluates hit/miss against the new `PC`.
- Reset (`RESET=0` at an edge) takes effect at that edge:
  - state IDLE, k=0, `buf_valid=0`, `buf_data=0`, `buf_tag=0`.
  - An in-progress fetch is abandoned; `MEM_READ` is low from the following cycle.
- Reset values of outputs:
  - `MEM_READ=0`, `MEM_ADDR=0`.
  - `INSTRUCTION=0`.
  - `BUSYWAIT` and `FAULT` follow the combinational rules with an empty buffer.

## Timing
- Hit: zero latency; `INSTRUCTION` is valid in the same cycle `PC` presents.
- Miss with `PC` presented in cycle T and `MEM_VALID` high every cycle:
  - T: IDLE.
  - T+1..T+4: FETCH.
  - T+5: FILL.
  - T+6: hit, `BUSYWAIT=0`.
  - `BUSYWAIT` is high for exactly 6 cycles.
- Each memory wait cycle (`MEM_READ=1`, `MEM_VALID=0`) adds one cycle.
- Address wrap: the highest word, at `2^ADDR_W-4`, is legal. `PC=2^ADDR_W` faults.

## Configuration
- `IFETCH_PREFETCH_EN` defined:
  - Adds a second buffer entry for next-line prefetch.
  - After each demand FILL, if `fetch_tag+1` is in range, enter PREFETCH and fetch that word with the same byte protocol.
  - `BUSYWAIT` stays low during PREFETCH for hits.
  - A hit on the prefetch entry copies it into the demand entry in one cycle, with zero added latency.
  - A demand miss during PREFETCH: the current byte read completes, the partial prefetch is discarded and the prefetch entry is invalidated, then FETCH starts next cycle.
- `IFETCH_PREFETCH_EN` undefined:
  - Single entry; no PREFETCH state.
  - Memory is idle except on demand misses.

## Test plan
- Memory bytes 0..3 = 10,32,54,76 (hex), `PC=0` after reset, `MEM_VALID` always 1 → `BUSYWAIT` high 6 cycles, then `INSTRUCTION=32'h76543210`; `MEM_ADDR` sequence 0,1,2,3.
- `MEM_VALID` pulses only every 3rd cycle → 4 transfers, `BUSYWAIT` released 2 cycles after the last `MEM_VALID`, correct word.
- `PC=2`, then `PC=32'h400` with `ADDR_W=10` → `FAULT=1`, `BUSYWAIT=0`, `INSTRUCTION=0`, `MEM_READ` never asserted.
- `PC=0`, fill, then `PC=0` again → `BUSYWAIT=0` immediately, no `MEM_READ`.
- `RESET=0` during the FETCH byte 2 read → next cycle `MEM_READ=0`, `buf_valid=0`; after release with `PC=0`, a full 6-cycle refetch.
- With `IFETCH_PREFETCH_EN`, `PC=0` then `PC=4` after prefetch completes → `PC=4` hits with `BUSYWAIT=0` and `INSTRUCTION` = bytes 4..7.
